id_ex_stage: RTL

- ID/EX pipeline register of the 5-stage RV32I core, with integrated load-use hazard detection.
- Captures decoded operands, register indices and control from ID and presents them to EX.
- Its ex_rs1/ex_rs2 outputs drive the forwarding unit's ID/EX source-register inputs.
- Inserts bubbles on load-use hazards and flushes, stalls PC/IF-ID, and keeps saturating stall/flush counters for performance debug.

---
 rtl/id_ex_stage.sv | 96 +++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion
// on hazards/flushes, and saturating stall/flush event counters.
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [XLEN-1:0]   id_rdata1,
  input  logic [XLEN-1:0]   id_rdata2,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              flush,
  input  logic              ex_hold,
  output logic              stall_front,
  output logic              ex_valid,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [XLEN-1:0]   ex_rdata1,
  output logic [XLEN-1:0]   ex_rdata2,
  output logic [XLEN-1:0]   ex_imm,
  output logic [XLEN-1:0]   ex_pc,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic hazard;
  logic load_p0;
  logic capture_p0;

  assign hazard = ex_valid & ex_mem_read & (ex_rd != 5'd0) & id_valid &
                  ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                   (id_uses_rs2 & (id_rs2 == ex_rd)));

  assign stall_front = (hazard | ex_hold) & ~flush;

  // Flush overrides hold; anything loaded that is not a capture is a bubble
  assign load_p0    = flush | ~ex_hold;
  assign capture_p0 = ~flush & ~ex_hold & ~hazard & id_valid;

  // ID -> EX register boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_rd        <= '0;
      ex_rdata1    <= '0;
      ex_rdata2    <= '0;
      ex_imm       <= '0;
      ex_pc        <= '0;
      ex_ctrl      <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      stall_cnt    <= '0;
      flush_cnt    <= '0;
    end else begin
      if (load_p0) begin
        ex_valid     <= capture_p0;
        ex_rs1       <= capture_p0 ? id_rs1       : '0;
        ex_rs2       <= capture_p0 ? id_rs2       : '0;
        ex_rd        <= capture_p0 ? id_rd        : '0;
        ex_rdata1    <= capture_p0 ? id_rdata1    : '0;
        ex_rdata2    <= capture_p0 ? id_rdata2    : '0;
        ex_imm       <= capture_p0 ? id_imm       : '0;
        ex_pc        <= capture_p0 ? id_pc        : '0;
        ex_ctrl      <= capture_p0 ? id_ctrl      : '0;
        ex_reg_write <= capture_p0 & id_reg_write;
        ex_mem_read  <= capture_p0 & id_mem_read;
      end
      if (flush)
        flush_cnt <= sat_inc(flush_cnt);
      else if (!ex_hold && hazard)
        stall_cnt <= sat_inc(stall_cnt);
    end
  end

endmodule
